ram_sweep_tester: RTL

Self-checking sequencer that drives the 256 x 16 single-port on-chip RAM (`myAlteraRAM`) as the initiating end of its address/data/rden/wren interface. On a start pulse it writes a deterministic pattern to every location, then reads every location back and compares each returned word against the expected pattern. It reports pass/fail, the error count and the first failing address. It sits beside the RAM in place of a testbench driver, so board-level bring-up can run the same sweep the simulation bench runs.

---
 rtl/ram_sweep_tester_if.sv | 11 +
 rtl/ram_sweep_tester.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ram_sweep_tester_if.sv
// Bus between the sweep sequencer (master) and the 256 x 16 single-port RAM (slave).
interface ram_sweep_tester_if;
  logic [7:0]  RamAddr;
  logic [15:0] RamDin;
  logic        RamWren;
  logic        RamRden;
  logic [15:0] RamQ;

  modport master (output RamAddr, output RamDin, output RamWren, output RamRden, input RamQ);
  modport slave  (input RamAddr, input RamDin, input RamWren, input RamRden, output RamQ);
endinterface

// File: rtl/ram_sweep_tester.sv
// Writes a seeded pattern to all 256 RAM words, reads them back through an
// RD_LAT-aligned compare pipe and reports pass/fail, error count and first bad address.
module ram_sweep_tester #(
  parameter int RD_LAT = 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic [15:0]               Seed,
  ram_sweep_tester_if.master        ram,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Pass,
  output logic [8:0]                ErrCount,
  output logic [7:0]                FirstErrAddr
);

  // One extra stage because RamQ only settles after the RD_LAT-th edge.
  localparam int PIPE_DEPTH = RD_LAT + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [15:0] pattern_f(input logic [7:0] a, input logic [15:0] seed);
    return {~a, a} ^ seed;
  endfunction

  state_t                  state_r, state_s;
  logic [7:0]              addr_r;
  logic [15:0]             seed_r;
  logic [15:0]             exp_pipe_r [PIPE_DEPTH];
  logic [7:0]              adr_pipe_r [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0]   vld_pipe_r;
  logic [8:0]              err_cnt_r, err_cnt_s;
  logic [7:0]              first_err_r;
  logic                    pass_r, busy_r, done_r;
  logic [7:0]              ram_addr_r, addr_s;
  logic [15:0]             ram_din_r, din_s;
  logic                    ram_wren_r, ram_rden_r, wren_s, rden_s, busy_s, done_s;
  logic                    start_ok_s, mismatch_s, drain_done_s;

  // Start acceptance, compare result and drain completion.
  always_comb begin
    start_ok_s   = Start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    mismatch_s   = vld_pipe_r[PIPE_DEPTH-1] && (ram.RamQ != exp_pipe_r[PIPE_DEPTH-1]);
    drain_done_s = (vld_pipe_r[PIPE_DEPTH-2:0] == {(PIPE_DEPTH-1){1'b0}});
    if (mismatch_s && (err_cnt_r != 9'd256)) begin
      err_cnt_s = err_cnt_r + 9'd1;
    end else begin
      err_cnt_s = err_cnt_r;
    end
  end

  // Next-state logic and next values of the registered RAM/status outputs.
  always_comb begin
    state_s = state_r;
    wren_s  = 1'b0;
    rden_s  = 1'b0;
    addr_s  = 8'd0;
    din_s   = 16'd0;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_s = ST_WRITE;
        else            state_s = ST_IDLE;
      end
      ST_WRITE: begin
        wren_s = 1'b1;
        addr_s = addr_r;
        din_s  = pattern_f(addr_r, seed_r);
        if (addr_r == 8'd255) state_s = ST_READ;
        else                  state_s = ST_WRITE;
      end
      ST_READ: begin
        rden_s = 1'b1;
        addr_s = addr_r;
        if (addr_r == 8'd255) state_s = ST_DRAIN;
        else                  state_s = ST_READ;
      end
      ST_DRAIN: begin
        if (drain_done_s) state_s = ST_DONE;
        else              state_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (start_ok_s) state_s = ST_WRITE;
        else            state_s = ST_DONE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = ((state_r == ST_WRITE) || (state_r == ST_READ) || (state_r == ST_DRAIN)) &&
             (state_s != ST_DONE);
    done_s = (state_s == ST_DONE);
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Address counter, compare pipe, results and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_r      <= 8'd0;
      seed_r      <= 16'd0;
      vld_pipe_r  <= {PIPE_DEPTH{1'b0}};
      err_cnt_r   <= 9'd0;
      first_err_r <= 8'd0;
      pass_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ram_addr_r  <= 8'd0;
      ram_din_r   <= 16'd0;
      ram_wren_r  <= 1'b0;
      ram_rden_r  <= 1'b0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        exp_pipe_r[i] <= 16'd0;
        adr_pipe_r[i] <= 8'd0;
      end
    end else begin
      ram_addr_r <= addr_s;
      ram_din_r  <= din_s;
      ram_wren_r <= wren_s;
      ram_rden_r <= rden_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      if (start_ok_s) begin
        seed_r      <= Seed;
        addr_r      <= 8'd0;
        err_cnt_r   <= 9'd0;
        first_err_r <= 8'd0;
        pass_r      <= 1'b0;
      end else begin
        if (wren_s || rden_s) addr_r <= addr_r + 8'd1;
        err_cnt_r <= err_cnt_s;
        if (mismatch_s && (err_cnt_r == 9'd0)) first_err_r <= adr_pipe_r[PIPE_DEPTH-1];
        if ((state_r == ST_DRAIN) && drain_done_s) pass_r <= (err_cnt_s == 9'd0);
      end
      vld_pipe_r    <= {vld_pipe_r[PIPE_DEPTH-2:0], rden_s};
      exp_pipe_r[0] <= pattern_f(addr_r, seed_r);
      adr_pipe_r[0] <= addr_r;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        exp_pipe_r[i] <= exp_pipe_r[i-1];
        adr_pipe_r[i] <= adr_pipe_r[i-1];
      end
    end
  end

  assign ram.RamAddr   = ram_addr_r;
  assign ram.RamDin    = ram_din_r;
  assign ram.RamWren   = ram_wren_r;
  assign ram.RamRden   = ram_rden_r;
  assign Busy          = busy_r;
  assign Done          = done_r;
  assign Pass          = pass_r;
  assign ErrCount      = err_cnt_r;
  assign FirstErrAddr  = first_err_r;

endmodule
